// File: rtl/ula_sequencial_if.sv
// Start/done handshake and operand/result bundle for ula_sequencial.
interface ula_sequencial_if #(
   parameter int W = 8
);
   logic           Inicio;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [3:0]     Sel_Op;
   logic [2*W-1:0] Resultado;
   logic           Maior;
   logic           Menor;
   logic           Igual;
   logic           Ocupado;
   logic           Pronto;
   logic           Erro;

   modport master (
      output Inicio, A, B, Sel_Op,
      input  Resultado, Maior, Menor, Igual, Ocupado, Pronto, Erro
   );

   modport slave (
      input  Inicio, A, B, Sel_Op,
      output Resultado, Maior, Menor, Igual, Ocupado, Pronto, Erro
   );
endinterface

// File: rtl/ula_sequencial.sv
// Multi-cycle W-bit ALU: iterative shift-add multiply, restoring divide.
// Define ULA_DIV_EN to build the divider; otherwise 0011/0100 are reserved.
module ula_sequencial #(
   parameter int W  = 8,
   parameter int CW = $clog2(W+1)
) (
   input logic          clk,
   input logic          rst,
   ula_sequencial_if.slave bus
);

   localparam logic [1:0] OCIOSO = 2'd0;
   localparam logic [1:0] CALC   = 2'd1;
   localparam logic [1:0] FIM    = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_NAND = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NOT  = 4'b1011;
`ifdef ULA_DIV_EN
   localparam logic [3:0] OP_QUO  = 4'b0011;
   localparam logic [3:0] OP_REM  = 4'b0100;
`endif

   localparam logic [CW-1:0] CNT_W = CW'(W);

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [3:0]     op_r;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] res_r;
   logic           maior_r;
   logic           menor_r;
   logic           igual_r;
   logic           erro_r;

   logic           accept;
   logic           is_mul_in;
   logic           is_div_in;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] acc_next;
   logic [2*W-1:0] final_res;
   logic           final_err;

   assign accept    = bus.Inicio && ((state == OCIOSO) || (state == FIM));
   assign is_mul_in = (bus.Sel_Op == OP_MUL);
`ifdef ULA_DIV_EN
   assign is_div_in = ((bus.Sel_Op == OP_QUO) || (bus.Sel_Op == OP_REM)) && (bus.B != '0);
`else
   assign is_div_in = 1'b0;
`endif

   // acc holds {upper, multiplier} for mul and {R, Q} for div
   assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, a_r};

`ifdef ULA_DIV_EN
   logic [W:0] div_shift;
   logic [W:0] div_trial;
   assign div_shift = {acc[2*W-1:W], acc[W-1]};
   assign div_trial = div_shift - {1'b0, b_r};
`endif

   always_comb begin
      acc_next = acc;
      if (op_r == OP_MUL) begin
         if (acc[0]) acc_next = {mul_sum, acc[W-1:1]};
         else        acc_next = {1'b0, acc[2*W-1:1]};
      end
`ifdef ULA_DIV_EN
      else begin
         if (!div_trial[W]) acc_next = {div_trial[W-1:0], acc[W-2:0], 1'b1};
         else               acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      end
`endif
   end

   always_comb begin
      final_res = '0;
      final_err = 1'b0;
      case (op_r)
         OP_ADD:  final_res[W:0]   = {1'b0, a_r} + {1'b0, b_r};
         OP_SUB:  final_res[W:0]   = {1'b0, a_r} - {1'b0, b_r};
         OP_MUL:  final_res        = acc;
`ifdef ULA_DIV_EN
         OP_QUO: begin
            if (b_r == '0) begin
               final_res[W-1:0] = '1;
               final_err        = 1'b1;
            end else begin
               final_res[W-1:0] = acc[W-1:0];
            end
         end
         OP_REM: begin
            if (b_r == '0) begin
               final_res[W-1:0] = a_r;
               final_err        = 1'b1;
            end else begin
               final_res[W-1:0] = acc[2*W-1:W];
            end
         end
`endif
         OP_AND:  final_res[W-1:0] = a_r & b_r;
         OP_OR:   final_res[W-1:0] = a_r | b_r;
         OP_NAND: final_res[W-1:0] = ~(a_r & b_r);
         OP_NOR:  final_res[W-1:0] = ~(a_r | b_r);
         OP_XOR:  final_res[W-1:0] = a_r ^ b_r;
         OP_NOT:  final_res[W-1:0] = ~a_r;
         default: final_err        = 1'b1;
      endcase
   end

   // Single-cycle ops pass through CALC with a zero count so every op
   // writes its outputs from the latched operands one edge after the count expires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= OCIOSO;
         cnt     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         op_r    <= '0;
         acc     <= '0;
         res_r   <= '0;
         maior_r <= 1'b0;
         menor_r <= 1'b0;
         igual_r <= 1'b0;
         erro_r  <= 1'b0;
      end else begin
         case (state)
            OCIOSO, FIM: begin
               if (accept) begin
                  a_r   <= bus.A;
                  b_r   <= bus.B;
                  op_r  <= bus.Sel_Op;
                  acc   <= is_div_in ? {{W{1'b0}}, bus.A} : {{W{1'b0}}, bus.B};
                  cnt   <= (is_mul_in || is_div_in) ? CNT_W : '0;
                  state <= CALC;
               end else begin
                  state <= OCIOSO;
               end
            end
            CALC: begin
               if (cnt != '0) begin
                  acc <= acc_next;
                  cnt <= cnt - 1'b1;
               end else begin
                  res_r   <= final_res;
                  erro_r  <= final_err;
                  maior_r <= (a_r > b_r);
                  menor_r <= (a_r < b_r);
                  igual_r <= (a_r == b_r);
                  state   <= FIM;
               end
            end
            default: state <= OCIOSO;
         endcase
      end
   end

   assign bus.Resultado = res_r;
   assign bus.Maior     = maior_r;
   assign bus.Menor     = menor_r;
   assign bus.Igual     = igual_r;
   assign bus.Erro      = erro_r;
   assign bus.Ocupado   = (state != OCIOSO);
   assign bus.Pronto    = (state == FIM);

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed-vector bench for ula_sequencial at W=8 and W=16.
// Expected division results follow ULA_DIV_EN as seen by this compile.
module tb_ula_sequencial;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

`ifdef ULA_DIV_EN
   localparam bit DIV = 1'b1;
`else
   localparam bit DIV = 1'b0;
`endif

   ula_sequencial_if #(.W(8))  bus8 ();
   ula_sequencial_if #(.W(16)) bus16 ();

   ula_sequencial #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   ula_sequencial #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        err;
      logic [2:0]  flg;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      output logic [15:0] r, output logic e, output logic [2:0] f, output int lat);
      @(negedge clk);
      bus8.Inicio = 1'b1; bus8.A = a; bus8.B = b; bus8.Sel_Op = op;
      @(posedge clk); #1;
      bus8.Inicio = 1'b0;
      lat = 0;
      while (lat < 40 && !bus8.Pronto) begin
         @(posedge clk); #1;
         lat++;
      end
      r = bus8.Resultado;
      e = bus8.Erro;
      f = {bus8.Maior, bus8.Menor, bus8.Igual};
      @(posedge clk); #1;
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       output logic [31:0] r, output logic e, output int lat);
      @(negedge clk);
      bus16.Inicio = 1'b1; bus16.A = a; bus16.B = b; bus16.Sel_Op = op;
      @(posedge clk); #1;
      bus16.Inicio = 1'b0;
      lat = 0;
      while (lat < 60 && !bus16.Pronto) begin
         @(posedge clk); #1;
         lat++;
      end
      r = bus16.Resultado;
      e = bus16.Erro;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r8;
      logic [31:0] r16;
      logic        e;
      logic [2:0]  f;
      int          lat;
      bit          saw_pronto;

      n_checks = 0;
      n_fail   = 0;

      vecs[0]  = '{4'b0000, 8'd50,  8'd30,  16'd80,    1'b0, 3'b100, 1};
      vecs[1]  = '{4'b0000, 8'd200, 8'd100, 16'd300,   1'b0, 3'b100, 1};
      vecs[2]  = '{4'b0001, 8'd30,  8'd50,  16'd492,   1'b0, 3'b010, 1};
      vecs[3]  = '{4'b0001, 8'd9,   8'd9,   16'd0,     1'b0, 3'b001, 1};
      vecs[4]  = '{4'b0010, 8'd20,  8'd20,  16'd400,   1'b0, 3'b001, 9};
      vecs[5]  = '{4'b0010, 8'd255, 8'd255, 16'd65025, 1'b0, 3'b001, 9};
      vecs[6]  = '{4'b0010, 8'd0,   8'd7,   16'd0,     1'b0, 3'b010, 9};
      vecs[7]  = '{4'b0010, 8'd13,  8'd0,   16'd0,     1'b0, 3'b100, 9};
      vecs[8]  = '{4'b0011, 8'd23,  8'd5,   DIV ? 16'd4 : 16'd0,   !DIV, 3'b100, DIV ? 9 : 1};
      vecs[9]  = '{4'b0100, 8'd23,  8'd5,   DIV ? 16'd3 : 16'd0,   !DIV, 3'b100, DIV ? 9 : 1};
      vecs[10] = '{4'b0011, 8'd23,  8'd0,   DIV ? 16'd255 : 16'd0, 1'b1, 3'b100, 1};
      vecs[11] = '{4'b0100, 8'd23,  8'd0,   DIV ? 16'd23 : 16'd0,  1'b1, 3'b100, 1};
      vecs[12] = '{4'b0110, 8'hF0,  8'hAA,  16'h00A0,  1'b0, 3'b100, 1};
      vecs[13] = '{4'b0111, 8'hF0,  8'hAA,  16'h00FA,  1'b0, 3'b100, 1};
      vecs[14] = '{4'b1000, 8'hF0,  8'hAA,  16'h005F,  1'b0, 3'b100, 1};
      vecs[15] = '{4'b1001, 8'hF0,  8'hAA,  16'h0005,  1'b0, 3'b100, 1};
      vecs[16] = '{4'b1010, 8'hF0,  8'hAA,  16'h005A,  1'b0, 3'b100, 1};
      vecs[17] = '{4'b1011, 8'hF0,  8'hAA,  16'h000F,  1'b0, 3'b100, 1};
      vecs[18] = '{4'b0101, 8'hF0,  8'hAA,  16'h0000,  1'b1, 3'b100, 1};
      vecs[19] = '{4'b1111, 8'd3,   8'd9,   16'h0000,  1'b1, 3'b010, 1};

      bus8.Inicio = 1'b0;  bus8.A = '0;  bus8.B = '0;  bus8.Sel_Op = '0;
      bus16.Inicio = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Sel_Op = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_resultado", 32'(bus8.Resultado), 32'd0);
      check("reset_flags", 32'({bus8.Maior, bus8.Menor, bus8.Igual}), 32'd0);
      check("reset_status", 32'({bus8.Ocupado, bus8.Pronto, bus8.Erro}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         op8(vecs[i].a, vecs[i].b, vecs[i].op, r8, e, f, lat);
         check($sformatf("vec%0d_res", i), 32'(r8), 32'(vecs[i].res));
         check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
         check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flg));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_idle_after", i), 32'({bus8.Ocupado, bus8.Pronto}), 32'd0);
      end

      // Inicio with new operands during a mul must be ignored
      @(negedge clk);
      bus8.Inicio = 1'b1; bus8.A = 8'd20; bus8.B = 8'd20; bus8.Sel_Op = 4'b0010;
      @(posedge clk); #1;
      bus8.Inicio = 1'b0;
      check("busy_after_accept", 32'(bus8.Ocupado), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus8.Inicio = 1'b1; bus8.A = 8'd3; bus8.B = 8'd3; bus8.Sel_Op = 4'b0000;
      @(negedge clk);
      bus8.Inicio = 1'b0;
      lat = 0;
      while (lat < 40 && !bus8.Pronto) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ignore_res", 32'(bus8.Resultado), 32'd400);
      check("ignore_pronto_seen", 32'(bus8.Pronto), 32'd1);
      @(posedge clk); #1;
      check("ignore_no_requeue", 32'({bus8.Ocupado, bus8.Pronto}), 32'd0);

      // Back-to-back with operand change after accept
      @(negedge clk);
      bus8.Inicio = 1'b1; bus8.A = 8'd1; bus8.B = 8'd2; bus8.Sel_Op = 4'b0000;
      @(posedge clk); #1;
      bus8.A = 8'd5; bus8.B = 8'd6;
      @(posedge clk); #1;
      check("b2b_first_pronto", 32'(bus8.Pronto), 32'd1);
      check("b2b_first_res", 32'(bus8.Resultado), 32'd3);
      @(posedge clk); #1;
      bus8.Inicio = 1'b0;
      check("b2b_second_busy", 32'({bus8.Ocupado, bus8.Pronto}), 32'b10);
      @(posedge clk); #1;
      check("b2b_second_pronto", 32'(bus8.Pronto), 32'd1);
      check("b2b_second_res", 32'(bus8.Resultado), 32'd11);
      @(posedge clk); #1;

      // Reset in the middle of a mul clears everything immediately
      @(negedge clk);
      bus8.Inicio = 1'b1; bus8.A = 8'd255; bus8.B = 8'd255; bus8.Sel_Op = 4'b0010;
      @(posedge clk); #1;
      bus8.Inicio = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_resultado", 32'(bus8.Resultado), 32'd0);
      check("midrst_flags", 32'({bus8.Maior, bus8.Menor, bus8.Igual}), 32'd0);
      check("midrst_status", 32'({bus8.Ocupado, bus8.Pronto, bus8.Erro}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_pronto = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (bus8.Pronto || bus8.Ocupado) saw_pronto = 1'b1;
      end
      check("midrst_no_pronto", 32'(saw_pronto), 32'd0);
      check("midrst_res_held", 32'(bus8.Resultado), 32'd0);

      // W=16
      op16(16'd1000, 16'd300, 4'b0010, r16, e, lat);
      check("w16_mul_res", r16, 32'd300000);
      check("w16_mul_latency", 32'(lat), 32'd17);
      check("w16_mul_err", 32'(e), 32'd0);
      op16(16'd1000, 16'd300, 4'b0100, r16, e, lat);
      check("w16_rem_res", r16, DIV ? 32'd100 : 32'd0);
      check("w16_rem_err", 32'(e), DIV ? 32'd0 : 32'd1);
      check("w16_rem_latency", 32'(lat), DIV ? 32'd17 : 32'd1);
      check("w16_rem_flags", 32'({bus16.Maior, bus16.Menor, bus16.Igual}), 32'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
